// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
//   state_e  - arbiter FSM states (IDLE / BUSY / DONE)
//   op_e     - latched operation (read / write)
//   ERR_DATA - read data returned when a transaction is abandoned on timeout
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   // A write request wins over a simultaneous read request; RdEn is masked.
   function automatic op_e resolve_op(input logic wr_en);
      return wr_en ? OP_WR : OP_RD;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles both requester ports, the SRAM controller port
// and the status outputs of the SRAM arbiter.
//   slave  - arbiter view (requests and controller responses in; enables,
//            read data, ready, grant and error out)
//   master - environment view (requesters plus controller), the mirror image
interface sram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0RdEnIn;
   logic              m0WrEnIn;
   logic [ADDR_W-1:0] m0AddrIn;
   logic [DATA_W-1:0] m0WDataIn;
   logic [DATA_W-1:0] m0RDataOut;
   logic              m0ReadyOut;
   logic              m1RdEnIn;
   logic              m1WrEnIn;
   logic [ADDR_W-1:0] m1AddrIn;
   logic [DATA_W-1:0] m1WDataIn;
   logic [DATA_W-1:0] m1RDataOut;
   logic              m1ReadyOut;
   logic              sRdEnOut;
   logic              sWrEnOut;
   logic [ADDR_W-1:0] sAddrOut;
   logic [DATA_W-1:0] sWDataOut;
   logic [DATA_W-1:0] sRDataIn;
   logic              sReadyIn;
   logic [1:0]        grantOut;
   logic              errOut;

   modport slave (
      input  m0RdEnIn, m0WrEnIn, m0AddrIn, m0WDataIn,
      input  m1RdEnIn, m1WrEnIn, m1AddrIn, m1WDataIn,
      input  sRDataIn, sReadyIn,
      output m0RDataOut, m0ReadyOut, m1RDataOut, m1ReadyOut,
      output sRdEnOut, sWrEnOut, sAddrOut, sWDataOut,
      output grantOut, errOut
   );

   modport master (
      output m0RdEnIn, m0WrEnIn, m0AddrIn, m0WDataIn,
      output m1RdEnIn, m1WrEnIn, m1AddrIn, m1WDataIn,
      output sRDataIn, sReadyIn,
      input  m0RDataOut, m0ReadyOut, m1RDataOut, m1ReadyOut,
      input  sRdEnOut, sWrEnOut, sAddrOut, sWDataOut,
      input  grantOut, errOut
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req_i        - request vector, bit n = port n
//   last_grant_i - index of the port granted most recently
//   grant_o      - one-hot winner, 2'b00 when nobody requests
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   // Pick the single requester, or on a tie the port that did not win last.
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between port 0 (MEM stage) and
// port 1 (loader/DMA). One request is latched at a time, the enables are held
// until the controller reports ready, then the owner gets a one-cycle ready
// pulse plus read data; a one-cycle enable gap follows every transaction.
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sram_arbiter_if.slave: both requester ports, controller port,
//          grantOut (one-hot owner) and errOut (sticky timeout flag)
// Optional build macro SRAM_ARB_TIMEOUT_EN: abandons a transaction after
// TIMEOUT_CYCLES busy cycles, returning ERR_DATA and setting errOut.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);

   // The busy counter is 8 bits wide, so the limit must fit in it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("sram_arbiter: TIMEOUT_CYCLES must be in 1..255");
   end

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [1:0]        grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [1:0]        req_s;
   logic [1:0]        pick_s;
   logic [1:0]        ready_s;
`ifdef SRAM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
`endif

   assign req_s = {bus.m1RdEnIn | bus.m1WrEnIn, bus.m0RdEnIn | bus.m0WrEnIn};

   rr_arb2 u_rr_arb2 (
      .req_i        (req_s),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_s)
   );

   // Next-state logic: grant in IDLE, wait for the controller in BUSY, gap in DONE.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_s[1]) begin
               op_d         = resolve_op(bus.m1WrEnIn);
               addr_d       = bus.m1AddrIn;
               wdata_d      = bus.m1WDataIn;
               grant_d      = 2'b10;
               last_grant_d = 1'b1;
               state_d      = BUSY;
            end else if (pick_s[0]) begin
               op_d         = resolve_op(bus.m0WrEnIn);
               addr_d       = bus.m0AddrIn;
               wdata_d      = bus.m0WDataIn;
               grant_d      = 2'b01;
               last_grant_d = 1'b0;
               state_d      = BUSY;
            end else begin
               state_d      = IDLE;
            end
`ifdef SRAM_ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
         end
         BUSY: begin
            // Requester inputs are not looked at here: a withdrawn request still completes.
            if (bus.sReadyIn) begin
               if (op_q == OP_RD && grant_q[1]) begin
                  rdata1_d = bus.sRDataIn;
               end else if (op_q == OP_RD) begin
                  rdata0_d = bus.sRDataIn;
               end else begin
                  rdata0_d = rdata0_q;
               end
               state_d = DONE;
            end
`ifdef SRAM_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               if (op_q == OP_RD && grant_q[1]) begin
                  rdata1_d = DATA_W'(ERR_DATA);
               end else if (op_q == OP_RD) begin
                  rdata0_d = DATA_W'(ERR_DATA);
               end else begin
                  rdata0_d = rdata0_q;
               end
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`else
            else begin
               state_d = BUSY;
            end
`endif
         end
         DONE: begin
            // Enables are already low; one idle cycle lets the controller settle.
            state_d = IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // Ready per port: not-frozen unless requesting, pulsed for the owner in DONE,
   // held low for a waiting non-owner while the controller is taken.
   always_comb begin
      ready_s = ~req_s;
      for (int i = 0; i < 2; i++) begin
         if (state_q == DONE && grant_q[i]) begin
            ready_s[i] = 1'b1;
         end else if (state_q != IDLE && req_s[i] && !grant_q[i]) begin
            ready_s[i] = 1'b0;
         end else begin
            ready_s[i] = ~req_s[i];
         end
      end
   end

   // State and datapath registers; reset drops the enables immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         op_q         <= OP_RD;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef SRAM_ARB_TIMEOUT_EN
   // Busy-cycle counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign bus.errOut = err_q;
`else
   assign bus.errOut = 1'b0;
`endif

   assign bus.sRdEnOut   = (state_q == BUSY) && (op_q == OP_RD);
   assign bus.sWrEnOut   = (state_q == BUSY) && (op_q == OP_WR);
   assign bus.sAddrOut   = addr_q;
   assign bus.sWDataOut  = wdata_q;
   assign bus.m0RDataOut = rdata0_q;
   assign bus.m1RDataOut = rdata1_q;
   assign bus.m0ReadyOut = ready_s[0];
   assign bus.m1ReadyOut = ready_s[1];
   assign bus.grantOut   = grant_q;

endmodule
